// File: rtl/rr_arb_mux4.sv
// Four-way round-robin arbiter with hold-limit preemption and a combinational data mux.
// The grant, sel and valid outputs are registered; out follows the owner's data input in the same cycle.
module rr_arb_mux4 #(
   parameter int DW       = 1,
   parameter int MAX_HOLD = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    req,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [DW-1:0] c,
   input  logic [DW-1:0] d,
   output logic [3:0]    gnt,
   output logic [1:0]    sel,
   output logic          valid,
   output logic [DW-1:0] out
);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_BUSY   = 1'b1;
   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

   logic [0:0] state_q, state_d;
   logic [3:0] gnt_q,   gnt_d;
   logic [1:0] sel_q,   sel_d;
   logic [1:0] ptr_q,   ptr_d;
   logic [7:0] cnt_q,   cnt_d;

   logic       issue;
   logic [3:0] cand;
   logic [3:0] others;
   logic [1:0] win;

   // First set bit of r searching upward from p, wrapping modulo 4.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] idx;
      logic       found;
      rr_pick = p;
      found   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx = p + 2'(i);
         if (!found && r[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

   assign others = req & ~gnt_q;
   assign win    = rr_pick(cand, ptr_q);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      issue   = 1'b0;
      cand    = req;
      case (state_q)
         S_IDLE: begin
            if (|req) issue = 1'b1;
         end
         default: begin
            if (!req[sel_q]) begin
               if (|others) begin
                  issue = 1'b1;
                  cand  = others;
               end else begin
                  state_d = S_IDLE;
                  gnt_d   = 4'b0000;
                  cnt_d   = 8'd0;
               end
            end else if (cnt_q == HOLD_MAX && |others) begin
               // Hold limit reached with competitors waiting: preempt the owner.
               issue = 1'b1;
               cand  = others;
            end else if (cnt_q != HOLD_MAX) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
      endcase
      if (issue) begin
         state_d = S_BUSY;
         gnt_d   = 4'b0001 << win;
         sel_d   = win;
         ptr_d   = win + 2'd1;
         cnt_d   = 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         gnt_q   <= 4'b0000;
         sel_q   <= 2'd0;
         ptr_q   <= 2'd0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign gnt   = gnt_q;
   assign sel   = sel_q;
   assign valid = (state_q == S_BUSY);

   always_comb begin
      out = '0;
      if (valid) begin
         case (sel_q)
            2'd0:    out = a;
            2'd1:    out = b;
            2'd2:    out = c;
            default: out = d;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arb_mux4.sv
// Table-driven bench for rr_arb_mux4: each vector's expected registered outputs are queued at drive
// time and popped one edge later; out and the grant invariants are checked on every vector.
module tb_rr_arb_mux4;

   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    req;
   logic [DW-1:0] a, b, c, d;
   logic [3:0]    gnt;
   logic [1:0]    sel;
   logic          valid;
   logic [DW-1:0] out;

   always #5 clk = ~clk;

   rr_arb_mux4 #(.DW(DW), .MAX_HOLD(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .a     (a),
      .b     (b),
      .c     (c),
      .d     (d),
      .gnt   (gnt),
      .sel   (sel),
      .valid (valid),
      .out   (out)
   );

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       vld;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic void add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                               input logic [1:0] s, input logic v);
      vec_t e;
      e.rst = r; e.req = rq; e.gnt = g; e.sel = s; e.vld = v;
      tbl.push_back(e);
   endfunction

   function automatic logic [DW-1:0] exp_out(input logic [1:0] s, input logic v);
      if (!v) return '0;
      case (s)
         2'd0:    return a;
         2'd1:    return b;
         2'd2:    return c;
         default: return d;
      endcase
   endfunction

   task automatic chk(input string nm, input int st, input logic [7:0] act, input logic [7:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s step %0d: got %0h expected %0h", nm, st, act, expv);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t e;
      rst = 1'b1; req = 4'b0000; a = '0; b = '0; c = '0; d = '0;

      // Single requester 2 for three cycles, then idle (sel keeps last owner)
      add(1, 4'b0000, 4'b0000, 2'd0, 0);
      add(0, 4'b0100, 4'b0100, 2'd2, 1);
      add(0, 4'b0100, 4'b0100, 2'd2, 1);
      add(0, 4'b0100, 4'b0100, 2'd2, 1);
      add(0, 4'b0000, 4'b0000, 2'd2, 0);
      add(0, 4'b0000, 4'b0000, 2'd2, 0);
      // Owner 0 drops while 2 waits: back-to-back to 2, then ptr=3 favours 3
      add(0, 4'b0001, 4'b0001, 2'd0, 1);
      add(0, 4'b0101, 4'b0001, 2'd0, 1);
      add(0, 4'b0100, 4'b0100, 2'd2, 1);
      add(0, 4'b0000, 4'b0000, 2'd2, 0);
      add(0, 4'b1111, 4'b1000, 2'd3, 1);
      // Reset mid-BUSY, then requester 0 wins first
      add(1, 4'b1111, 4'b0000, 2'd0, 0);
      add(0, 4'b1001, 4'b0001, 2'd0, 1);
      add(0, 4'b1000, 4'b1000, 2'd3, 1);
      add(0, 4'b0000, 4'b0000, 2'd3, 0);
      // Pulse on requester 2 during owner 3 is not remembered
      add(0, 4'b1000, 4'b1000, 2'd3, 1);
      add(0, 4'b1100, 4'b1000, 2'd3, 1);
      add(0, 4'b1000, 4'b1000, 2'd3, 1);
      add(0, 4'b0000, 4'b0000, 2'd3, 0);
      // Lone requester 1 for 20 cycles; then saturated hold is preempted by 0
      for (int i = 0; i < 20; i++) add(0, 4'b0010, 4'b0010, 2'd1, 1);
      add(0, 4'b0011, 4'b0001, 2'd0, 1);
      add(0, 4'b0000, 4'b0000, 2'd0, 0);
      // All requesting: each owner holds exactly 8 cycles in order 0,1,2,3,0
      add(1, 4'b0000, 4'b0000, 2'd0, 0);
      for (int i = 0; i < 40; i++) begin
         logic [1:0] o;
         o = 2'((i / 8) % 4);
         add(0, 4'b1111, 4'b0001 << o, o, 1);
      end

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         rst = tbl[i].rst;
         req = tbl[i].req;
         a = DW'($urandom); b = DW'($urandom); c = DW'($urandom); d = DW'($urandom);
         exp_q.push_back(tbl[i]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         chk("gnt",      i, {4'b0, gnt},     {4'b0, e.gnt});
         chk("sel",      i, {6'b0, sel},     {6'b0, e.sel});
         chk("valid",    i, {7'b0, valid},   {7'b0, e.vld});
         chk("out",      i, 8'(out),         8'(exp_out(e.sel, e.vld)));
         chk("onehot0",  i, {7'b0, $onehot0(gnt)}, 8'd1);
         chk("valid_or", i, {7'b0, valid},   {7'b0, |gnt});
         a = DW'($urandom); b = DW'($urandom); c = DW'($urandom); d = DW'($urandom);
         #1;
         chk("out_follow", i, 8'(out), 8'(exp_out(e.sel, e.vld)));
      end
      chk("sb_empty", tbl.size(), 8'(exp_q.size()), 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rr_arb_mux4.md
RR_ARB_MUX4 -- requirements
Module: rr_arb_mux4

Interface
REQ-001 Parameter: DW, default 1, width in bits of each requester data input and of out.
REQ-002 Parameter: MAX_HOLD, default 8, maximum consecutive granted cycles before forced release when others are waiting (legal range 2..255).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: req  input  4  request per requester; bit i belongs to requester i.
REQ-006 Port: a, b, c, d  input  DW each  data of requesters 0, 1, 2, 3.
REQ-007 Port: gnt  output  4  registered one-hot grant; all-zero when no owner.
REQ-008 Port: sel  output  2  registered index of current owner; holds last owner when idle.
REQ-009 Port: valid  output  1  registered; 1 exactly when gnt is non-zero.
REQ-010 Port: out  output  DW  combinational mux of a/b/c/d by sel when valid=1; 0 when valid=0.

Function
REQ-011 The block SHALL have two states: IDLE (no owner) and BUSY (one owner, gnt one-hot).
REQ-012 The block SHALL keep a 2-bit priority pointer ptr; search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first index with its req bit high wins.
REQ-013 IDLE, req==0: remain IDLE, gnt=0, valid=0.
REQ-014 IDLE, req!=0 at edge k: at edge k the winner is latched; gnt/sel/valid reflect it from cycle k+1 (one-cycle grant latency); state -> BUSY.
REQ-015 On every grant issue, ptr SHALL update to (winner+1) mod 4 at the same edge.
REQ-016 BUSY, req[sel]=1 and hold limit not reached: keep owner, gnt/sel unchanged.
REQ-017 BUSY, req[sel]=0: release at that edge; if any other req bit is high, grant the next winner at the same edge (back-to-back, no idle cycle), else -> IDLE with gnt=0.
REQ-018 A 8-bit hold counter SHALL reset to 1 on each grant issue and increment each BUSY cycle the owner is kept, saturating at MAX_HOLD.
REQ-019 BUSY, counter==MAX_HOLD, req[sel]=1, and any other req bit high: force release and grant the next winner at that edge (preemption).
REQ-020 BUSY, counter==MAX_HOLD, req[sel]=1, no other request: owner kept, counter stays at MAX_HOLD.
REQ-021 A preempted requester keeping req high SHALL re-enter arbitration normally at lowest priority (ptr already past it).
REQ-022 gnt SHALL never have more than one bit set; valid SHALL equal |gnt in every cycle.
REQ-023 Requests that rise and fall while another owner holds the grant SHALL NOT be remembered (no request latching).
REQ-024 out SHALL follow changes on the owner's data input in the same cycle (no data register).

Reset
REQ-025 rst=1 at an edge SHALL force state IDLE, gnt=4'b0000, sel=2'b00, valid=0, ptr=0, counter=0; out=0 consequently.
REQ-026 rst SHALL take priority over all arbitration, including mid-BUSY; ownership is dropped with no release handshake.
REQ-027 First arbitration after reset release SHALL start with requester 0 at highest priority.

Verification
REQ-028 Reset then req=4'b1111 held: gnt sequence per MAX_HOLD window 0001,0010,0100,1000,0001; each owner held exactly 8 cycles; valid=1 throughout.
REQ-029 req=4'b0100 for 3 cycles then 0: gnt=0100, sel=2 one cycle after req rise, out=c; gnt=0000, valid=0, out=0 one cycle after req falls.
REQ-030 Owner 0 drops req while req[2] high: next cycle gnt=0100 with no idle cycle; ptr=3.
REQ-031 Single requester 1 held 20 cycles, others low: gnt=0010 for all 20 cycles, no preemption.
REQ-032 rst asserted for one cycle while gnt=1000: next cycle gnt=0000, sel=0, valid=0; with req=4'b1001 afterward, grant goes to 0 first.
REQ-033 Every cycle of every test: gnt one-hot or zero, valid==|gnt, out==selected input or 0.
